// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer: sweep modes, FSM states,
// and the default widths that match the DDS phase-accumulator datapath.
package dds_pkg;

  localparam int KW_DEF = 32;
  localparam int PW_DEF = 11;
  localparam int NW_DEF = 16;
  localparam int DW_DEF = 16;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS: accepts one sweep config, then
// steps the frequency word K through the sweep, holding each value for a
// programmable dwell. Supports single-shot, repeating and triangle sweeps.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int PW = PW_DEF,
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [NW-1:0] cfg_n_steps,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_p,
  input  logic [1:0]    cfg_mode,
  input  logic          abort,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          busy,
  output logic          step_stb,
  output logic          done
);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;
  logic          busy_q, busy_d;
  logic          step_stb_q, step_stb_d;
  logic          done_q, done_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [NW-1:0] idx_q, idx_d;
  logic          dir_q, dir_d;           // 0 = stepping up, 1 = stepping down
  logic [KW-1:0] k_start_q, k_start_d;
  logic [KW-1:0] k_step_q, k_step_d;
  logic [NW-1:0] n_steps_q, n_steps_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    mode_q, mode_d;

  assign cfg_ready = (state_q == IDLE) & ~abort & ~rst;

  assign K        = k_q;
  assign P        = p_q;
  assign busy     = busy_q;
  assign step_stb = step_stb_q;
  assign done     = done_q;

  // Next-state logic: handshake, dwell countdown, stepping and end-of-pass handling
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    p_d        = p_q;
    busy_d     = busy_q;
    step_stb_d = 1'b0;
    done_d     = 1'b0;
    dcnt_d     = dcnt_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    k_start_d  = k_start_q;
    k_step_d   = k_step_q;
    n_steps_d  = n_steps_q;
    dwell_d    = dwell_q;
    mode_d     = mode_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready) begin
          k_start_d = cfg_k_start;
          k_step_d  = cfg_k_step;
          n_steps_d = cfg_n_steps;
          dwell_d   = cfg_dwell;
          mode_d    = cfg_mode;
          k_d       = cfg_k_start;
          p_d       = cfg_p;
          dcnt_d    = cfg_dwell;
          idx_d     = '0;
          dir_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DW'(1);
        end else if (idx_q != n_steps_q) begin
          k_d        = dir_q ? (k_q - k_step_q) : (k_q + k_step_q);
          idx_d      = idx_q + NW'(1);
          dcnt_d     = dwell_q;
          step_stb_d = 1'b1;
        end else if (mode_q == MODE_TRIANGLE && n_steps_q != '0) begin
          // The turnaround step already moves one step into the new pass,
          // so the index restarts at 1 and the endpoint is not repeated.
          dir_d      = ~dir_q;
          k_d        = dir_q ? (k_q + k_step_q) : (k_q - k_step_q);
          idx_d      = NW'(1);
          dcnt_d     = dwell_q;
          step_stb_d = 1'b1;
        end else if (mode_q == MODE_REPEAT || mode_q == MODE_TRIANGLE) begin
          k_d        = k_start_q;
          idx_d      = '0;
          dcnt_d     = dwell_q;
          step_stb_d = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      p_q        <= '0;
      busy_q     <= 1'b0;
      step_stb_q <= 1'b0;
      done_q     <= 1'b0;
      dcnt_q     <= '0;
      idx_q      <= '0;
      dir_q      <= 1'b0;
      k_start_q  <= '0;
      k_step_q   <= '0;
      n_steps_q  <= '0;
      dwell_q    <= '0;
      mode_q     <= MODE_SINGLE;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      p_q        <= p_d;
      busy_q     <= busy_d;
      step_stb_q <= step_stb_d;
      done_q     <= done_d;
      dcnt_q     <= dcnt_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      k_start_q  <= k_start_d;
      k_step_q   <= k_step_d;
      n_steps_q  <= n_steps_d;
      dwell_q    <= dwell_d;
      mode_q     <= mode_d;
    end
  end

endmodule
